acq_timing_manager: RTL and testbench

Parametrised sensor-acquisition timing manager for NUM_CH sensor channels. It generates a scheduler trigger every (user_ratio+1) PWM-carrier event qualifiers. It timestamps each enabled channel's done edge relative to that trigger, and interrupts the PS when all enabled channels finish. It adds what the single-window, fixed-6-channel manager lacks:
- enable mask latched per window
- first-edge-only capture
- saturating time base
- timeout detection with a missed-channel mask
- overrun detection

It sits between the PWM carrier, the sensor interface IPs, and the PS interrupt controller.

---
 rtl/acq_timing_manager.sv | 181 ++++++++++++++++++
 tb/tb_acq_timing_manager.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_timing_manager.sv
// Sensor-acquisition timing manager: derives a scheduler trigger from PWM qualifiers,
// timestamps each enabled channel's first done edge per window, and raises sticky interrupts.
module acq_timing_manager #(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 16,
  parameter int RATIO_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    event_qualifier,
  input  logic [RATIO_W-1:0]      user_ratio,
  input  logic [CNT_W-1:0]        timeout_cycles,
  input  logic [NUM_CH-1:0]       en_bits,
  input  logic [NUM_CH-1:0]       done,
  input  logic                    reset_sched_isr,
  output logic [NUM_CH-1:0]       en_ch,
  output logic                    trigger,
  output logic [CNT_W-1:0]        count_time,
  output logic [NUM_CH*CNT_W-1:0] ch_time,
  output logic [NUM_CH-1:0]       done_mask,
  output logic [NUM_CH-1:0]       missed_mask,
  output logic                    sched_isr,
  output logic                    timeout_isr,
  output logic                    overrun,
  output logic [1:0]              state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [RATIO_W-1:0] RATIO_ONE = {{(RATIO_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [RATIO_W-1:0] qual_cnt_r;
  logic [NUM_CH-1:0]  en_lat_r;
  logic [NUM_CH-1:0]  done_q_r;
  logic [NUM_CH-1:0]  edge_s;
  logic [NUM_CH-1:0]  cap_s;
  logic [NUM_CH-1:0]  mask_nxt_s;
  logic               in_acq_s;
  logic               all_done_s;
  logic               tmo_hit_s;
  logic               set_sched_s;
  logic               set_tmo_s;
  logic               set_ovr_s;

  assign en_ch      = en_bits;
  assign state      = state_r;
  assign edge_s     = done & ~done_q_r;
  // Captures happen only in an open window; the trigger cycle itself discards edges.
  assign in_acq_s   = (state_r == ST_ACQ) && !trigger;
  assign cap_s      = in_acq_s ? (edge_s & en_lat_r & ~done_mask) : {NUM_CH{1'b0}};
  assign mask_nxt_s = done_mask | cap_s;
  assign all_done_s = (mask_nxt_s == en_lat_r);
  assign tmo_hit_s  = (timeout_cycles != {CNT_W{1'b0}}) && (count_time >= timeout_cycles);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (trigger) begin
      if (en_bits != {NUM_CH{1'b0}}) begin
        state_nxt_s = ST_ACQ;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_ACQ: begin
          if (all_done_s) begin
            state_nxt_s = ST_DONE;
          end else if (tmo_hit_s) begin
            state_nxt_s = ST_TMO;
          end else begin
            state_nxt_s = ST_ACQ;
          end
        end
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_DONE: state_nxt_s = ST_DONE;
        ST_TMO:  state_nxt_s = ST_TMO;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode: all-done wins over timeout in the same cycle
  always_comb begin
    set_sched_s = in_acq_s && all_done_s;
    set_tmo_s   = in_acq_s && !all_done_s && tmo_hit_s;
    set_ovr_s   = trigger && (state_r == ST_ACQ);
  end

  // Qualifier divider and trigger pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      qual_cnt_r <= {RATIO_W{1'b0}};
      trigger    <= 1'b0;
    end else if (event_qualifier && (qual_cnt_r == user_ratio)) begin
      qual_cnt_r <= {RATIO_W{1'b0}};
      trigger    <= 1'b1;
    end else if (event_qualifier) begin
      qual_cnt_r <= qual_cnt_r + RATIO_ONE;
      trigger    <= 1'b0;
    end else begin
      trigger    <= 1'b0;
    end
  end

  // Saturating time base restarted by each trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      count_time <= {CNT_W{1'b0}};
    end else if (trigger) begin
      count_time <= {CNT_W{1'b0}};
    end else if (count_time != CNT_MAX) begin
      count_time <= count_time + CNT_ONE;
    end
  end

  // Done history; all-ones at reset so a level held high is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q_r <= {NUM_CH{1'b1}};
    end else begin
      done_q_r <= done;
    end
  end

  // Window bookkeeping: latched mask, captured channels, timestamps, missed channels
  always_ff @(posedge clk) begin
    if (rst) begin
      en_lat_r    <= {NUM_CH{1'b0}};
      done_mask   <= {NUM_CH{1'b0}};
      missed_mask <= {NUM_CH{1'b0}};
      ch_time     <= {(NUM_CH*CNT_W){1'b0}};
    end else if (trigger) begin
      en_lat_r  <= en_bits;
      done_mask <= {NUM_CH{1'b0}};
      if (set_ovr_s) begin
        missed_mask <= en_lat_r & ~done_mask;
      end
    end else begin
      done_mask <= mask_nxt_s;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_s[i]) begin
          ch_time[i*CNT_W +: CNT_W] <= count_time;
        end
      end
      if (set_tmo_s) begin
        missed_mask <= en_lat_r & ~mask_nxt_s;
      end
    end
  end

  // Sticky interrupt flags; a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sched_isr   <= 1'b0;
      timeout_isr <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sched_isr   <= set_sched_s | (sched_isr   & ~reset_sched_isr);
      timeout_isr <= set_tmo_s   | (timeout_isr & ~reset_sched_isr);
      overrun     <= set_ovr_s   | (overrun     & ~reset_sched_isr);
    end
  end

endmodule

// File: tb/tb_acq_timing_manager.sv
// Randomised and directed bench for acq_timing_manager against a window-level behavioural model.
module tb_acq_timing_manager;
  localparam int NCH = 8;
  localparam int CW  = 8;
  localparam int RW  = 8;

  logic              clk;
  logic              rst;
  logic              event_qualifier;
  logic [RW-1:0]     user_ratio;
  logic [CW-1:0]     timeout_cycles;
  logic [NCH-1:0]    en_bits;
  logic [NCH-1:0]    done;
  logic              reset_sched_isr;
  logic [NCH-1:0]    en_ch;
  logic              trigger;
  logic [CW-1:0]     count_time;
  logic [NCH*CW-1:0] ch_time;
  logic [NCH-1:0]    done_mask;
  logic [NCH-1:0]    missed_mask;
  logic              sched_isr;
  logic              timeout_isr;
  logic              overrun;
  logic [1:0]        state;

  acq_timing_manager #(.NUM_CH(NCH), .CNT_W(CW), .RATIO_W(RW)) dut (
    .clk(clk), .rst(rst), .event_qualifier(event_qualifier), .user_ratio(user_ratio),
    .timeout_cycles(timeout_cycles), .en_bits(en_bits), .done(done),
    .reset_sched_isr(reset_sched_isr), .en_ch(en_ch), .trigger(trigger),
    .count_time(count_time), .ch_time(ch_time), .done_mask(done_mask),
    .missed_mask(missed_mask), .sched_isr(sched_isr), .timeout_isr(timeout_isr),
    .overrun(overrun), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: window phase 0 idle, 1 open, 2 complete, 3 timed out
  int       m_qual;
  bit       m_trig;
  int       m_since;
  int       m_phase;
  logic [NCH-1:0] m_lat, m_got, m_missed, m_prev;
  int       m_ts [NCH];
  bit       m_sched, m_tmo, m_ovr;

  function automatic int ct_of(int s);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NCH-1:0] edges;
    int ct;
    bit set_s, set_t, set_o;
    if (rst) begin
      m_qual = 0; m_trig = 0; m_since = 0; m_phase = 0;
      m_lat = '0; m_got = '0; m_missed = '0; m_prev = '1;
      for (int i = 0; i < NCH; i++) m_ts[i] = 0;
      m_sched = 0; m_tmo = 0; m_ovr = 0;
    end else begin
      edges = done & ~m_prev;
      m_prev = done;
      ct = ct_of(m_since);
      set_s = 0; set_t = 0; set_o = 0;
      if (m_trig) begin
        if (m_phase == 1) begin
          set_o = 1;
          m_missed = m_lat & ~m_got;
        end
        m_lat = en_bits;
        m_got = '0;
        m_phase = (en_bits != 0) ? 1 : 0;
        m_since = 0;
      end else begin
        m_since++;
        if (m_phase == 1) begin
          for (int i = 0; i < NCH; i++)
            if (edges[i] && m_lat[i] && !m_got[i]) begin
              m_ts[i] = ct;
              m_got[i] = 1'b1;
            end
          if (m_got == m_lat) begin
            m_phase = 2; set_s = 1;
          end else if (timeout_cycles != 0 && ct >= int'(timeout_cycles)) begin
            m_phase = 3; set_t = 1;
            m_missed = m_lat & ~m_got;
          end
        end
      end
      if (reset_sched_isr) begin
        m_sched = 0; m_tmo = 0; m_ovr = 0;
      end
      if (set_s) m_sched = 1;
      if (set_t) m_tmo = 1;
      if (set_o) m_ovr = 1;
      if (event_qualifier) begin
        if (m_qual == int'(user_ratio)) begin
          m_qual = 0; m_trig = 1;
        end else begin
          m_qual = (m_qual + 1) % 256; m_trig = 0;
        end
      end else begin
        m_trig = 0;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("trigger", trigger, m_trig);
      chk("count_time", count_time, ct_of(m_since));
      chk("state", state, m_phase);
      chk("done_mask", done_mask, m_got);
      chk("missed_mask", missed_mask, m_missed);
      chk("sched_isr", sched_isr, m_sched);
      chk("timeout_isr", timeout_isr, m_tmo);
      chk("overrun", overrun, m_ovr);
      chk("en_ch", en_ch, en_bits);
      for (int i = 0; i < NCH; i++) chk("ch_time", ch_time[i*CW +: CW], m_ts[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // One qualifier with ratio 0 -> trigger, then the trigger cycle; returns at count_time 0
  task automatic fire();
    user_ratio = '0;
    event_qualifier = 1'b1;
    step();
    event_qualifier = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; event_qualifier = 1'b0; user_ratio = '0; timeout_cycles = '0;
    en_bits = '0; done = '0; reset_sched_isr = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_state", state, 0);
    chk("rst_count", count_time, 0);
    chk("rst_trigger", trigger, 0);
    rst = 1'b0;

    // Ratio 3: trigger one cycle after every 4th qualifier, one cycle wide
    user_ratio = 8'd3;
    for (int q = 1; q <= 4; q++) begin
      event_qualifier = 1'b1;
      step();
      chk("ratio_trig", trigger, (q == 4) ? 1 : 0);
      event_qualifier = 1'b0;
      step();
      chk("ratio_width", trigger, 0);
      repeat (8) step();
    end
    user_ratio = 8'd0;
    event_qualifier = 1'b1;
    step();
    chk("ratio0_a", trigger, 1);
    step();
    chk("ratio0_b", trigger, 1);
    event_qualifier = 1'b0;
    step();

    // Capture and all-done
    en_bits = 8'h05;
    fire();
    chk("acq_state", state, 1);
    chk("acq_count", count_time, 0);
    repeat (7) step();
    done[0] = 1'b1;
    step();
    repeat (12) step();
    done[2] = 1'b1;
    step();
    chk("ts0", ch_time[7:0], 7);
    chk("ts2", ch_time[23:16], 20);
    chk("done_state", state, 2);
    chk("done_sched", sched_isr, 1);
    chk("done_mask5", done_mask, 8'h05);
    chk("done_count", count_time, 21);
    reset_sched_isr = 1'b1;
    step();
    reset_sched_isr = 1'b0;
    chk("sched_clr", sched_isr, 0);
    chk("mask_kept", done_mask, 8'h05);
    done = '0;
    step();

    // Timeout with one channel missing
    en_bits = 8'h03;
    timeout_cycles = 8'd50;
    fire();
    repeat (10) step();
    done[0] = 1'b1;
    step();
    repeat (39) step();
    chk("pre_tmo_state", state, 1);
    chk("pre_tmo_count", count_time, 50);
    step();
    chk("tmo_state", state, 3);
    chk("tmo_isr", timeout_isr, 1);
    chk("tmo_missed", missed_mask, 8'h02);
    chk("tmo_sched", sched_isr, 0);
    chk("tmo_ts0", ch_time[7:0], 10);
    reset_sched_isr = 1'b1;
    done = '0;
    step();
    reset_sched_isr = 1'b0;
    timeout_cycles = '0;

    // Overrun, then set-vs-clear priority
    en_bits = 8'h01;
    fire();
    repeat (5) step();
    fire();
    chk("ovr_flag", overrun, 1);
    chk("ovr_missed", missed_mask, 8'h01);
    chk("ovr_state", state, 1);
    chk("ovr_mask", done_mask, 0);
    done[0] = 1'b1;
    reset_sched_isr = 1'b1;
    step();
    chk("prio_sched", sched_isr, 1);
    chk("prio_ovr_clr", overrun, 0);
    reset_sched_isr = 1'b0;
    done = '0;
    fire();
    step();
    event_qualifier = 1'b1;
    step();
    event_qualifier = 1'b0;
    reset_sched_isr = 1'b1;
    step();
    reset_sched_isr = 1'b0;
    chk("prio_ovr_set", overrun, 1);
    step();

    // Edge hygiene
    done[1] = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    en_bits = 8'h06;
    fire();
    repeat (3) step();
    chk("held_no_cap", done_mask, 0);
    done[1] = 1'b0;
    step();
    done[1] = 1'b1;
    step();
    chk("first_ts1", ch_time[15:8], 4);
    chk("first_mask", done_mask, 8'h02);
    done[1] = 1'b0;
    step();
    done[1] = 1'b1;
    step();
    chk("second_ts1", ch_time[15:8], 4);
    event_qualifier = 1'b1;
    step();
    event_qualifier = 1'b0;
    done[2] = 1'b1;
    step();
    chk("trig_edge_drop", done_mask, 0);
    step();
    chk("trig_edge_late", done_mask, 0);
    done = '0;
    step();

    // Saturation, latched mask, reset mid-window
    en_bits = '0;
    fire();
    repeat (300) step();
    chk("saturate", count_time, 255);
    en_bits = 8'h01;
    fire();
    en_bits = 8'h03;
    repeat (2) step();
    done[0] = 1'b1;
    step();
    chk("latched_done", state, 2);
    done = '0;
    en_bits = 8'h01;
    fire();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_state", state, 0);
    chk("midrst_count", count_time, 0);
    chk("midrst_ts", ch_time, 0);
    chk("midrst_sched", sched_isr, 0);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) user_ratio = 8'($urandom_range(0, 3));
      event_qualifier = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0)
        timeout_cycles = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(20, 80));
      if ($urandom_range(0, 99) == 0) en_bits = 8'($urandom);
      done = done ^ (8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom));
      reset_sched_isr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
